// File: rtl/usb_ep_pkg.sv
// Shared EP0 descriptor types, ROM layout offsets and LUT sizing helper.
package usb_ep_pkg;

  typedef enum logic [7:0] {
    DEVICE = 8'd1,
    CONFIG = 8'd2,
    STRING = 8'd3
  } DescType;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_LEN0,
    ST_LEN1,
    ST_STREAM,
    ST_PKT_WAIT,
    ST_ZLP_WAIT
  } state_e;

  localparam int CONF_WTOTALLENGTH_OFFSET = 2;
  localparam int BLENGTH_OFFSET           = 0;

  // String zero (LANGID table) only exists when there is a string section.
  function automatic int lutEntries(input int numConfigs, input int numStrDescs);
    return numConfigs + ((numStrDescs > 0) ? numStrDescs + 1 : 0);
  endfunction

endpackage

// File: rtl/desc_lut_lookup.sv
// Combinational descriptor start-address resolution and request range check.
// hit_o low means the request is unsupported and the host must be STALLed.
module desc_lut_lookup
  import usb_ep_pkg::*;
#(
  parameter int ROM_IDX_WID   = 8,
  parameter int NUM_CONFIGS   = 1,
  parameter int NUM_STR_DESCS = 2,
  parameter int LUT_WID       = ROM_IDX_WID * lutEntries(NUM_CONFIGS, NUM_STR_DESCS)
) (
  input  logic [7:0]             descType_i,
  input  logic [7:0]             descIdx_i,
  input  logic [LUT_WID-1:0]     lut_i,
  output logic [ROM_IDX_WID-1:0] start_o,
  output logic                   hit_o
);

  localparam int NUM_ENTRIES = lutEntries(NUM_CONFIGS, NUM_STR_DESCS);

  always_comb begin
    start_o = '0;
    hit_o   = 1'b0;
    if (descType_i == DEVICE) begin
      hit_o = 1'b1;
    end else begin
      // Config entries occupy slots 0..NUM_CONFIGS-1, strings follow.
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        if (descType_i == CONFIG && e < NUM_CONFIGS && int'(descIdx_i) == e) begin
          hit_o   = 1'b1;
          start_o = lut_i[e*ROM_IDX_WID +: ROM_IDX_WID];
        end
        if (descType_i == STRING && NUM_STR_DESCS > 0 && e >= NUM_CONFIGS &&
            int'(descIdx_i) == e - NUM_CONFIGS) begin
          hit_o   = 1'b1;
          start_o = lut_i[e*ROM_IDX_WID +: ROM_IDX_WID];
        end
      end
    end
  end

endmodule

// File: rtl/ep0_desc_streamer.sv
// Streams a GET_DESCRIPTOR data stage from the descriptor ROM in MPS packets.
// Bytes move on valid_o && ready_i; packets advance only on nextPacket_i/retry_i.
module ep0_desc_streamer
  import usb_ep_pkg::*;
#(
  parameter int ROM_IDX_WID     = 8,
  parameter int NUM_CONFIGS     = 1,
  parameter int NUM_STR_DESCS   = 2,
  parameter int MAX_PACKET_SIZE = 8,
  parameter int LUT_WID         = ROM_IDX_WID * lutEntries(NUM_CONFIGS, NUM_STR_DESCS)
) (
  input  logic                   clk48_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [7:0]             descType_i,
  input  logic [7:0]             descIdx_i,
  input  logic [15:0]            wLength_i,
  input  logic                   abort_i,
  input  logic                   nextPacket_i,
  input  logic                   retry_i,
  output logic [ROM_IDX_WID-1:0] romAddr_o,
  input  logic [7:0]             romData_i,
  input  logic [LUT_WID-1:0]     descStartIdx_i,
  output logic [7:0]             data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   pktLast_o,
  output logic                   pktDone_o,
  output logic                   zlp_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic                   busy_o
);

  localparam int CNT_W = $clog2(MAX_PACKET_SIZE) + 1;

  state_e                 state_q, state_d;
  logic [7:0]             type_q, type_d;
  logic [7:0]             idx_q, idx_d;
  logic [15:0]            wlen_q, wlen_d;
  logic [ROM_IDX_WID-1:0] start_q, start_d;
  logic [ROM_IDX_WID-1:0] addr_q, addr_d;
  logic [ROM_IDX_WID-1:0] pktStartAddr_q, pktStartAddr_d;
  logic [15:0]            total_q, total_d;
  logic [15:0]            rem_q, rem_d;
  logic [15:0]            pktStartRem_q, pktStartRem_d;
  logic [CNT_W-1:0]       pktCnt_q, pktCnt_d;
  logic                   hiByte_q, hiByte_d;
  logic                   pktDone_q, pktDone_d;
  logic                   zlp_q, zlp_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;

  logic [ROM_IDX_WID-1:0] lutStart;
  logic                   lutHit;
  logic                   lastByte;
  logic                   enterStream;
  logic [15:0]            xferLen;

  desc_lut_lookup #(
    .ROM_IDX_WID   (ROM_IDX_WID),
    .NUM_CONFIGS   (NUM_CONFIGS),
    .NUM_STR_DESCS (NUM_STR_DESCS),
    .LUT_WID       (LUT_WID)
  ) u_lookup (
    .descType_i (type_q),
    .descIdx_i  (idx_q),
    .lut_i      (descStartIdx_i),
    .start_o    (lutStart),
    .hit_o      (lutHit)
  );

  assign lastByte = (pktCnt_q == CNT_W'(MAX_PACKET_SIZE - 1)) || (rem_q == 16'd1);

  always_comb begin
    state_d        = state_q;
    type_d         = type_q;
    idx_d          = idx_q;
    wlen_d         = wlen_q;
    start_d        = start_q;
    addr_d         = addr_q;
    pktStartAddr_d = pktStartAddr_q;
    total_d        = total_q;
    rem_d          = rem_q;
    pktStartRem_d  = pktStartRem_q;
    pktCnt_d       = pktCnt_q;
    hiByte_d       = hiByte_q;
    pktDone_d      = 1'b0;
    zlp_d          = 1'b0;
    done_d         = 1'b0;
    error_d        = 1'b0;
    enterStream    = 1'b0;
    xferLen        = 16'd0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          type_d  = descType_i;
          idx_d   = descIdx_i;
          wlen_d  = wLength_i;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (!lutHit) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else if (wlen_q == 16'd0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          start_d = lutStart;
          addr_d  = lutStart + ROM_IDX_WID'(BLENGTH_OFFSET);
          state_d = ST_LEN0;
        end
      end
      ST_LEN0: begin
        total_d = {8'h00, romData_i};
        if (type_q == CONFIG) begin
          addr_d   = start_q + ROM_IDX_WID'(CONF_WTOTALLENGTH_OFFSET);
          hiByte_d = 1'b0;
          state_d  = ST_LEN1;
        end else begin
          enterStream = 1'b1;
        end
      end
      ST_LEN1: begin
        // wTotalLength is little endian: low byte first, then high byte.
        if (!hiByte_q) begin
          total_d[7:0] = romData_i;
          addr_d       = addr_q + 1'b1;
          hiByte_d     = 1'b1;
        end else begin
          total_d[15:8] = romData_i;
          hiByte_d      = 1'b0;
          enterStream   = 1'b1;
        end
      end
      ST_STREAM: begin
        if (ready_i) begin
          addr_d   = addr_q + 1'b1;
          rem_d    = rem_q - 16'd1;
          pktCnt_d = pktCnt_q + 1'b1;
          if (lastByte) begin
            pktDone_d = 1'b1;
            state_d   = ST_PKT_WAIT;
          end
        end
      end
      ST_PKT_WAIT: begin
        if (retry_i) begin
          addr_d   = pktStartAddr_q;
          rem_d    = pktStartRem_q;
          pktCnt_d = '0;
          state_d  = ST_STREAM;
        end else if (nextPacket_i) begin
          if (rem_q != 16'd0) begin
            pktStartAddr_d = addr_q;
            pktStartRem_d  = rem_q;
            pktCnt_d       = '0;
            state_d        = ST_STREAM;
          end else if (pktCnt_q == CNT_W'(MAX_PACKET_SIZE) && total_q < wlen_q) begin
            // Short of wLength and last packet full: host needs a ZLP to end.
            zlp_d   = 1'b1;
            state_d = ST_ZLP_WAIT;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_ZLP_WAIT: begin
        if (retry_i) begin
          zlp_d = 1'b1;
        end else if (nextPacket_i) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (enterStream) begin
      xferLen = (total_d < wlen_q) ? total_d : wlen_q;
      if (xferLen == 16'd0) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end else begin
        rem_d          = xferLen;
        pktStartRem_d  = xferLen;
        addr_d         = start_q;
        pktStartAddr_d = start_q;
        pktCnt_d       = '0;
        state_d        = ST_STREAM;
      end
    end

    if (abort_i) begin
      state_d        = ST_IDLE;
      addr_d         = '0;
      pktStartAddr_d = '0;
      total_d        = '0;
      rem_d          = '0;
      pktStartRem_d  = '0;
      pktCnt_d       = '0;
      hiByte_d       = 1'b0;
      pktDone_d      = 1'b0;
      zlp_d          = 1'b0;
      done_d         = 1'b0;
      error_d        = 1'b0;
    end
  end

  always_ff @(posedge clk48_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      type_q         <= '0;
      idx_q          <= '0;
      wlen_q         <= '0;
      start_q        <= '0;
      addr_q         <= '0;
      pktStartAddr_q <= '0;
      total_q        <= '0;
      rem_q          <= '0;
      pktStartRem_q  <= '0;
      pktCnt_q       <= '0;
      hiByte_q       <= 1'b0;
      pktDone_q      <= 1'b0;
      zlp_q          <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      type_q         <= type_d;
      idx_q          <= idx_d;
      wlen_q         <= wlen_d;
      start_q        <= start_d;
      addr_q         <= addr_d;
      pktStartAddr_q <= pktStartAddr_d;
      total_q        <= total_d;
      rem_q          <= rem_d;
      pktStartRem_q  <= pktStartRem_d;
      pktCnt_q       <= pktCnt_d;
      hiByte_q       <= hiByte_d;
      pktDone_q      <= pktDone_d;
      zlp_q          <= zlp_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  assign romAddr_o = addr_q;
  assign valid_o   = (state_q == ST_STREAM);
  assign data_o    = valid_o ? romData_i : 8'h00;
  assign pktLast_o = valid_o && lastByte;
  assign pktDone_o = pktDone_q;
  assign zlp_o     = zlp_q;
  assign done_o    = done_q;
  assign error_o   = error_q;
  assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ep0_desc_streamer.sv
// Bench for ep0_desc_streamer: two instances (MPS 8 and MPS 16) behind one ROM.
module tb_ep0_desc_streamer;

  localparam int LUT_WID = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, start, abort, nxt, retry, ready;
  logic [7:0]         dtype, didx;
  logic [15:0]        wlen;
  logic [LUT_WID-1:0] lut;
  logic [7:0]         rom [256];
  int                 sel;
  int                 total_c = 0;
  int                 bad_c   = 0;

  logic [7:0] addrA, romA, dataA, addrB, romB, dataB;
  logic validA, lastA, pdA, zlpA, doneA, errA, busyA;
  logic validB, lastB, pdB, zlpB, doneB, errB, busyB;
  logic startA, startB, nxtA, nxtB, retA, retB, rdyA, rdyB;
  logic [7:0] obs_addr, obs_data;
  logic obs_valid, obs_last, obs_pd, obs_zlp, obs_done, obs_err, obs_busy;

  assign romA   = rom[addrA];
  assign romB   = rom[addrB];
  assign startA = start && (sel == 0);
  assign startB = start && (sel == 1);
  assign nxtA   = nxt && (sel == 0);
  assign nxtB   = nxt && (sel == 1);
  assign retA   = retry && (sel == 0);
  assign retB   = retry && (sel == 1);
  assign rdyA   = ready && (sel == 0);
  assign rdyB   = ready && (sel == 1);

  assign obs_addr  = (sel == 1) ? addrB  : addrA;
  assign obs_data  = (sel == 1) ? dataB  : dataA;
  assign obs_valid = (sel == 1) ? validB : validA;
  assign obs_last  = (sel == 1) ? lastB  : lastA;
  assign obs_pd    = (sel == 1) ? pdB    : pdA;
  assign obs_zlp   = (sel == 1) ? zlpB   : zlpA;
  assign obs_done  = (sel == 1) ? doneB  : doneA;
  assign obs_err   = (sel == 1) ? errB   : errA;
  assign obs_busy  = (sel == 1) ? busyB  : busyA;

  ep0_desc_streamer #(.MAX_PACKET_SIZE(8)) dut_a (
    .clk48_i(clk), .rst_i(rst), .start_i(startA), .descType_i(dtype), .descIdx_i(didx),
    .wLength_i(wlen), .abort_i(abort), .nextPacket_i(nxtA), .retry_i(retA),
    .romAddr_o(addrA), .romData_i(romA), .descStartIdx_i(lut), .data_o(dataA),
    .valid_o(validA), .ready_i(rdyA), .pktLast_o(lastA), .pktDone_o(pdA), .zlp_o(zlpA),
    .done_o(doneA), .error_o(errA), .busy_o(busyA)
  );

  ep0_desc_streamer #(.MAX_PACKET_SIZE(16)) dut_b (
    .clk48_i(clk), .rst_i(rst), .start_i(startB), .descType_i(dtype), .descIdx_i(didx),
    .wLength_i(wlen), .abort_i(abort), .nextPacket_i(nxtB), .retry_i(retB),
    .romAddr_o(addrB), .romData_i(romB), .descStartIdx_i(lut), .data_o(dataB),
    .valid_o(validB), .ready_i(rdyB), .pktLast_o(lastB), .pktDone_o(pdB), .zlp_o(zlpB),
    .done_o(doneB), .error_o(errB), .busy_o(busyB)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_c++;
    assert (obs === exp) else begin
      bad_c++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the host sees the first min(total, wLength) descriptor bytes,
  // cut into MPS packets, with a ZLP when the last packet is full but short.
  task automatic run_req(input int s, input logic [7:0] ty, input logic [7:0] ix,
                         input logic [15:0] wl, input int retry_pkt, input bit zlp_retry);
    int mps, st, tot, n, k, pk_k, inpkt, pkt, cyc, zlps, exp_zlps;
    bit exp_err, got_err, got_done, retried, zretried, seen_valid;
    mps = (s == 1) ? 16 : 8;
    exp_err = 1'b1;
    st = 0;
    if (ty == 8'd1) begin
      exp_err = 1'b0;
    end else if (ty == 8'd2 && ix < 8'd1) begin
      exp_err = 1'b0;
      st = int'(lut[int'(ix)*8 +: 8]);
    end else if (ty == 8'd3 && ix <= 8'd2) begin
      exp_err = 1'b0;
      st = int'(lut[(1 + int'(ix))*8 +: 8]);
    end
    tot = (ty == 8'd2) ? int'(rom[(st+2) & 255]) + 256 * int'(rom[(st+3) & 255])
                       : int'(rom[st]);
    n = exp_err ? 0 : ((tot < int'(wl)) ? tot : int'(wl));
    exp_zlps = (n > 0 && n % mps == 0 && n < int'(wl)) ? (zlp_retry ? 2 : 1) : 0;

    k = 0; pk_k = 0; inpkt = 0; pkt = 0; zlps = 0;
    got_err = 0; got_done = 0; retried = 0; zretried = 0; seen_valid = 0;
    sel = s; dtype = ty; didx = ix; wlen = wl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!got_err && !got_done && cyc < 3000) begin
      nxt = 1'b0; retry = 1'b0; ready = 1'b0;
      if (obs_err) begin
        got_err = 1'b1;
        chk("err_latency", 32'(cyc), 32'd2);
      end
      if (obs_done) begin
        got_done = 1'b1;
        if (wl == 16'd0) chk("wl0_latency", 32'(cyc), 32'd2);
      end
      if (obs_valid) seen_valid = 1'b1;
      if (obs_zlp) begin
        zlps++;
        if (zlp_retry && !zretried) begin retry = 1'b1; zretried = 1'b1; end
        else nxt = 1'b1;
      end
      if (obs_pd) begin
        chk("pkt_len", 32'(inpkt), 32'((n - pk_k < mps) ? n - pk_k : mps));
        if (pkt == retry_pkt && !retried) begin
          retried = 1'b1; retry = 1'b1; k = pk_k;
        end else begin
          nxt = 1'b1; pk_k = k; pkt++;
        end
        inpkt = 0;
      end
      if (obs_valid) begin
        ready = ($urandom_range(0, 3) != 0);
        if (ready) begin
          chk("data", 32'(obs_data), 32'(rom[(st + k) & 255]));
          chk("pkt_last", 32'(obs_last), 32'((inpkt == mps - 1) || (k == n - 1)));
          k++; inpkt++;
        end
      end
      if (!got_err && !got_done) begin
        @(negedge clk);
        cyc++;
      end
    end
    nxt = 1'b0; retry = 1'b0; ready = 1'b0;
    chk("finished_in_budget", 32'(got_err | got_done), 32'd1);
    chk("error", 32'(got_err), 32'(exp_err));
    chk("done", 32'(got_done), 32'(!exp_err));
    chk("byte_count", 32'(k), 32'(n));
    chk("zlp_count", 32'(zlps), 32'(exp_zlps));
    if (exp_err) chk("no_valid_on_error", 32'(seen_valid), 32'd0);
    @(negedge clk);
    chk("idle_after", 32'(obs_busy), 32'd0);
  endtask

  initial begin
    int tys [6];
    tys = '{1, 2, 3, 3, 2, 5};
    rst = 1'b1; start = 1'b0; abort = 1'b0; nxt = 1'b0; retry = 1'b0; ready = 1'b0;
    dtype = '0; didx = '0; wlen = '0; sel = 0;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[0] = 8'd18; rom[1] = 8'd1;
    rom[32] = 8'd9; rom[33] = 8'd2; rom[34] = 8'd32; rom[35] = 8'd0;
    rom[64] = 8'd4;
    rom[80] = 8'd16;
    rom[96] = 8'd0;
    lut = {8'd96, 8'd80, 8'd64, 8'd32};

    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      chk("rst_valid", 32'(obs_valid), 32'd0);
      chk("rst_busy", 32'(obs_busy), 32'd0);
      chk("rst_done", 32'(obs_done), 32'd0);
      chk("rst_error", 32'(obs_err), 32'd0);
      chk("rst_zlp", 32'(obs_zlp), 32'd0);
      chk("rst_pktdone", 32'(obs_pd), 32'd0);
      chk("rst_last", 32'(obs_last), 32'd0);
      chk("rst_addr", 32'(obs_addr), 32'd0);
      chk("rst_data", 32'(obs_data), 32'd0);
    end
    sel = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_req(0, 8'd1, 8'd0, 16'd64, -1, 1'b0);
    run_req(0, 8'd1, 8'd0, 16'd9, -1, 1'b0);
    run_req(1, 8'd2, 8'd0, 16'd255, -1, 1'b0);
    run_req(0, 8'd1, 8'd0, 16'd64, 0, 1'b0);
    run_req(0, 8'd3, 8'd3, 16'd64, -1, 1'b0);
    run_req(0, 8'd6, 8'd0, 16'd64, -1, 1'b0);
    run_req(0, 8'd2, 8'd1, 16'd64, -1, 1'b0);
    run_req(0, 8'd2, 8'd0, 16'd32, -1, 1'b0);
    run_req(0, 8'd2, 8'd0, 16'd40, 3, 1'b1);
    run_req(0, 8'd3, 8'd2, 16'd64, -1, 1'b0);
    run_req(0, 8'd1, 8'd0, 16'd0, -1, 1'b0);
    run_req(0, 8'd3, 8'd1, 16'd16, -1, 1'b0);
    run_req(0, 8'd3, 8'd1, 16'd20, 1, 1'b0);
    run_req(1, 8'd1, 8'd0, 16'd18, -1, 1'b0);
    run_req(1, 8'd3, 8'd0, 16'd255, -1, 1'b0);

    // Abort mid-stream with the consumer stalled, plus a start_i while busy.
    sel = 0; dtype = 8'd1; didx = 8'd0; wlen = 16'd64; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_abort_valid", 32'(obs_valid), 32'd1);
    dtype = 8'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_start_ignored_err", 32'(obs_err), 32'd0);
    chk("busy_start_ignored_valid", 32'(obs_valid), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", 32'(obs_valid), 32'd0);
    chk("abort_busy", 32'(obs_busy), 32'd0);
    chk("abort_addr", 32'(obs_addr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(obs_done), 32'd0);
      chk("abort_no_error", 32'(obs_err), 32'd0);
    end
    run_req(0, 8'd1, 8'd0, 16'd64, -1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_req(int'($urandom_range(0, 1)), 8'(tys[$urandom_range(0, 5)]),
              8'($urandom_range(0, 3)), 16'($urandom_range(0, 80)),
              int'($urandom_range(0, 4)) - 1, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total_c, bad_c);
    $finish;
  end

endmodule

// File: doc/ep0_desc_streamer.md
Name: ep0_desc_streamer

Overview:
- Read-side counterpart of the EP0 descriptor ROM. Serves GET_DESCRIPTOR data stages.
- On a request it resolves the descriptor's ROM start address from the ROM's descStartIdx LUT and determines the descriptor length from the ROM contents.
- It then reads the ROM byte by byte and streams min(wLength, descriptor length) bytes to the EP0 IN path as MAX_PACKET_SIZE packets, with ZLP signalling, packet retry and abort.

Parameters:
- ROM_IDX_WID, 8, width of ROM byte address and of each LUT entry.
- NUM_CONFIGS, 1, number of configuration descriptors (LUT entries 0..NUM_CONFIGS-1).
- NUM_STR_DESCS, 2, number of string descriptors excluding string zero. 0 means no string section.
- MAX_PACKET_SIZE, 8, EP0 max packet size in bytes. Legal values: 8, 16, 32, 64.
- LUT_WID, ROM_IDX_WID*(NUM_CONFIGS+(NUM_STR_DESCS>0 ? NUM_STR_DESCS+1 : 0)), width of the packed LUT bus.

Ports:
- clk48_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  one-cycle request pulse; sampled only in IDLE
- descType_i  in  8  wValue high byte: 1 = device, 2 = config, 3 = string
- descIdx_i  in  8  wValue low byte
- wLength_i  in  16  host-requested length
- abort_i  in  1  new SETUP / bus reset; highest priority
- nextPacket_i  in  1  previous packet ACKed, send the next one
- retry_i  in  1  previous packet not ACKed, resend it
- romAddr_o  out  ROM_IDX_WID  ROM read address; ROM read is combinational
- romData_i  in  8  ROM data for romAddr_o, same cycle
- descStartIdx_i  in  LUT_WID  packed start-address LUT from the ROM
- data_o  out  8  stream byte
- valid_o  out  1  data_o valid
- ready_i  in  1  consumer accepts the byte when valid_o && ready_i
- pktLast_o  out  1  qualifies the final byte of the current packet
- pktDone_o  out  1  one-cycle pulse: packet fully handed over
- zlp_o  out  1  one-cycle pulse: a zero-length packet is required
- done_o  out  1  one-cycle pulse: transfer complete (final packet ACKed)
- error_o  out  1  one-cycle pulse: unsupported request; upper layer STALLs
- busy_o  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- data_o = romData_i, driven combinationally from the romAddr_o register.
- States: IDLE, LOOKUP, LEN0, LEN1, STREAM, PKT_WAIT, ZLP_WAIT.
- IDLE: on start_i go to LOOKUP and latch type, index and wLength.
- LOOKUP (1 cycle): compute the start address.
  - type 1: start = 0.
  - type 2 with idx < NUM_CONFIGS: start = LUT[idx].
  - type 3 with NUM_STR_DESCS > 0 and idx <= NUM_STR_DESCS: start = LUT[NUM_CONFIGS+idx].
  - Any other request: pulse error_o and return to IDLE.
  - wLength == 0: pulse done_o and return to IDLE; no data is read.
  - Otherwise load romAddr_o and go to LEN0.
- LEN0: total = romData_i (bLength).
  - For type 2, set romAddr_o = start+2 and go to LEN1.
  - For other types, go to STREAM.
- LEN1 (config only): total[7:0] = romData_i; the next cycle reads start+3 into total[15:8] (wTotalLength, little endian).
- On entering STREAM:
  - remaining = min(total, wLength), 16 bit.
  - romAddr_o = start.
  - pktStartAddr and pktStartRem are saved.
- STREAM:
  - valid_o = 1.
  - On each handshake: romAddr_o++, remaining--, pktCnt++.
  - pktLast_o = (pktCnt == MAX_PACKET_SIZE-1) || (remaining == 1).
  - After the last-byte handshake: pulse pktDone_o and go to PKT_WAIT.
- PKT_WAIT:
  - retry_i: restore romAddr_o/remaining from pktStart*, clear pktCnt, go to STREAM.
  - nextPacket_i with remaining > 0: save pktStart*, go to STREAM.
  - nextPacket_i with remaining == 0:
    - If the final packet was full (pktCnt == MAX_PACKET_SIZE) and min(total, wLength) < wLength: pulse zlp_o and go to ZLP_WAIT.
    - Else pulse done_o and go to IDLE.
  - retry_i wins over nextPacket_i when both are asserted.
- ZLP_WAIT:
  - retry_i: pulse zlp_o again.
  - nextPacket_i: pulse done_o and go to IDLE.
- abort_i in any state: next cycle state = IDLE and all outputs 0; no done_o or error_o is emitted.
- start_i outside IDLE is ignored.
- ROM address wrap is not possible for a legal LUT.
- A descriptor with total == 0 streams nothing and completes as done_o.

Decomposition:
- usb_ep_pkg gets:
  - DescType enum (DEVICE=1, CONFIG=2, STRING=3).
  - Named constants CONF_WTOTALLENGTH_OFFSET = 2 and BLENGTH_OFFSET = 0.
  - Helper function lutEntries(numConfigs, numStrDescs).
- The LUT index and range-check logic is split out as sub-module desc_lut_lookup (combinational).
- The top level holds the FSM and counters.

Test Plan:
- Device descriptor, bLength 18, wLength 64, MPS 8, nextPacket after each packet -> packets of 8, 8, 2 bytes; pktLast on bytes 7, 15, 17; no zlp_o; done_o after the third nextPacket.
- Same request with wLength 9 -> packets of 8 and 1 bytes equal to ROM[0..8]; done_o; no zlp_o.
- Config 0, wTotalLength 32 (bytes 0x20, 0x00 at start+2/+3), wLength 255, MPS 16 -> packets of 16 and 16 bytes, then zlp_o, then done_o after nextPacket.
- Retry: device descriptor, retry_i after the first packet -> the second packet repeats bytes 0..7 identically; total transfer is unchanged.
- Type 3 with idx = NUM_STR_DESCS+1 -> error_o pulse 2 cycles after start_i, valid_o never asserted. Type 6 -> error_o.
- abort_i mid-STREAM with ready_i held low -> valid_o 0 and busy_o 0 next cycle. A new start_i is then accepted normally.
